d_ip_timer_ctrl: RTL and testbench
==================================

# d_ip_timer_ctrl

Sequencing controller for the timer IP's down-counter. It accepts start/stop commands and configuration from the register block, runs a prescaled down-count from a loaded value, and emits a one-cycle terminal-count pulse. It also maintains the sticky interrupt and selects between one-shot and periodic (auto-reload) operation. It sits between the register file and the interrupt output, and its counter value feeds the readable count register.

## Interface

Parameters:
- SIZE, 32, counter and load-value width
- PSC_W, 8, prescaler width

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle command: (re)load and run
- stop  in  1  single-cycle command: halt and return to IDLE
- mode  in  1  0 = one-shot, 1 = periodic; sampled on accepted start
- load_val  in  SIZE  count start value; sampled on accepted start
- psc_val  in  PSC_W  prescale divisor minus one; sampled on accepted start
- irq_clr  in  1  clears irq
- cnt  out  SIZE  current count value
- tc  out  1  terminal-count pulse, one cycle
- irq  out  1  sticky interrupt
- busy  out  1  high while in RUN

## Operation

- States: IDLE, RUN, DONE.
- Internal shadow registers hold load_val, psc_val and mode. They are written only on an accepted start, and reload always uses the shadow copies. A shadow copy of psc_val feeds the prescaler counter psc_cnt.
- Accepted start is start=1, stop=0, load_val!=0.
  - From IDLE or DONE: capture the shadows, cnt<=load_val, psc_cnt<=psc_val, go to RUN.
  - From RUN: same actions, i.e. a restart.
- start with load_val==0: ignored; state, cnt and shadows are unchanged.
- stop in any state, which has priority over start:
  - go to IDLE, psc_cnt<=0, cnt holds its current value.
  - No tc is produced in the stop cycle.
- RUN prescaler:
  - If psc_cnt==0: tick, and psc_cnt<=shadow psc.
  - Otherwise psc_cnt<=psc_cnt-1.
- RUN on tick:
  - If cnt>1: cnt<=cnt-1.
  - If cnt==1: tc<=1 and irq set.
    - Periodic: cnt<=shadow load, stay in RUN.
    - One-shot: cnt<=0, go to DONE.
- DONE: cnt=0 and busy=0. Only start or stop leave DONE.
- irq: set by a terminal count and cleared by irq_clr. If both happen in the same cycle, set wins.
- tc is registered and is deasserted in every cycle other than the one following a terminal tick.
- busy is registered and equals (state==RUN).
- Arithmetic:
  - cnt never wraps below 0, because decrement happens only when cnt>1.
  - Count period = load_val*(psc_val+1) cycles. The product is never formed in hardware.
- Reset: state IDLE; cnt, tc, irq, busy, psc_cnt and all shadows are 0. Reset mid-run aborts with no tc.

## Timing

- Timing is stated with start asserted in cycle 0.
- Cycle 1: cnt=load_val (N), busy=1.
- Each count value is held for psc_val+1 (P+1) cycles. cnt=1 is held through cycle N(P+1).
- Cycle N(P+1)+1:
  - tc=1 and irq=1.
  - Periodic: cnt=N, busy=1.
  - One-shot: cnt=0, busy=0.
- Periodic: further tc pulses occur every N(P+1) cycles.
- N=1, P=0: tc occurs in cycle 2, then every cycle in periodic mode.
- A restart in RUN behaves exactly as a start from IDLE. Prescaler phase is discarded.
- stop in cycle k: in cycle k+1, busy=0 and cnt equals its cycle-k value.
- irq_clr in cycle k: irq=0 in cycle k+1, unless a tc sets it in that cycle.
- Outputs change only on the clock edge; there are no combinational paths from inputs to outputs.

## Test plan

- Reset check: assert rst for 2 cycles and release -> cnt=0, tc=0, irq=0, busy=0 in the first cycle after release.
- One-shot: mode=0, load_val=5, psc_val=0, start in cycle 0 -> cnt 5,4,3,2,1 in cycles 1-5; cycle 6 has tc=1, irq=1, cnt=0, busy=0; tc low afterwards.
- Periodic with prescaler: mode=1, load_val=3, psc_val=2 -> tc in cycles 10, 19, 28. Change load_val to 7 mid-run -> period unchanged at 9.
- Stop/start priority: assert stop while cnt=4, and in another run assert stop and start together -> IDLE, cnt frozen at 4, no tc, busy=0 the next cycle.
- Zero load and restart: start with load_val=0 -> ignored, stays IDLE. Start with N=10, then restart at cnt=6 with N=2 -> cnt=2 the next cycle, tc 2 cycles later (psc=0).
- irq collision: assert irq_clr in the same cycle as a terminal tick -> irq stays 1. A later irq_clr -> irq=0 the next cycle.

Source files
------------

// File: rtl/d_ip_timer_ctrl.sv
// Timer down-count sequencer: start/stop command handling, prescaled countdown,
// one-shot/periodic reload, terminal-count pulse and sticky interrupt.
module d_ip_timer_ctrl #(
  parameter int SIZE  = 32,
  parameter int PSC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [SIZE-1:0]  load_val,
  input  logic [PSC_W-1:0] psc_val,
  input  logic             irq_clr,
  output logic [SIZE-1:0]  cnt,
  output logic             tc,
  output logic             irq,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [SIZE-1:0]  cnt_reg, cnt_next;
  logic [SIZE-1:0]  load_reg, load_next;
  logic [PSC_W-1:0] psc_cnt_reg, psc_cnt_next;
  logic [PSC_W-1:0] psc_reg, psc_next;
  logic             mode_reg, mode_next;
  logic             tc_reg, tc_next;
  logic             irq_reg, irq_next;
  logic             busy_reg, busy_next;
  logic             start_ok;
  logic             tc_set;

  // A zero load would never reach a terminal count, so it is not a valid start.
  assign start_ok = start && !stop && (load_val != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      load_reg    <= '0;
      psc_cnt_reg <= '0;
      psc_reg     <= '0;
      mode_reg    <= 1'b0;
      tc_reg      <= 1'b0;
      irq_reg     <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      load_reg    <= load_next;
      psc_cnt_reg <= psc_cnt_next;
      psc_reg     <= psc_next;
      mode_reg    <= mode_next;
      tc_reg      <= tc_next;
      irq_reg     <= irq_next;
      busy_reg    <= busy_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    load_next    = load_reg;
    psc_cnt_next = psc_cnt_reg;
    psc_next     = psc_reg;
    mode_next    = mode_reg;
    tc_set       = 1'b0;

    if (stop) begin
      state_next   = IDLE;
      psc_cnt_next = '0;
    end else if (start_ok) begin
      load_next    = load_val;
      psc_next     = psc_val;
      mode_next    = mode;
      cnt_next     = load_val;
      psc_cnt_next = psc_val;
      state_next   = RUN;
    end else if (state_reg == RUN) begin
      if (psc_cnt_reg == '0) begin
        psc_cnt_next = psc_reg;
        if (cnt_reg > SIZE'(1)) begin
          cnt_next = cnt_reg - SIZE'(1);
        end else if (cnt_reg == SIZE'(1)) begin
          tc_set = 1'b1;
          if (mode_reg) begin
            cnt_next = load_reg;
          end else begin
            cnt_next   = '0;
            state_next = DONE;
          end
        end
      end else begin
        psc_cnt_next = psc_cnt_reg - PSC_W'(1);
      end
    end

    // A terminal count in the same cycle as irq_clr leaves irq set.
    tc_next   = tc_set;
    irq_next  = tc_set | (irq_reg & ~irq_clr);
    busy_next = (state_next == RUN);
  end

  assign cnt  = cnt_reg;
  assign tc   = tc_reg;
  assign irq  = irq_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_d_ip_timer_ctrl.sv
// Self-checking bench for d_ip_timer_ctrl: directed scenarios plus a randomized
// run compared against an elapsed-time reference model.
module tb_d_ip_timer_ctrl;

  localparam int SIZE  = 32;
  localparam int PSC_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             mode = 1'b0;
  logic [SIZE-1:0]  load_val = '0;
  logic [PSC_W-1:0] psc_val = '0;
  logic             irq_clr = 1'b0;
  logic [SIZE-1:0]  cnt;
  logic             tc;
  logic             irq;
  logic             busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: a run is described by the cycles elapsed since its start.
  bit          m_run;
  bit          m_mode;
  bit          m_irq;
  int          m_e;
  int          m_n;
  int          m_p;
  logic [31:0] m_frozen;
  logic [31:0] exp_cnt;
  logic        exp_tc;
  logic        exp_busy;

  d_ip_timer_ctrl #(.SIZE(SIZE), .PSC_W(PSC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .load_val(load_val), .psc_val(psc_val), .irq_clr(irq_clr),
    .cnt(cnt), .tc(tc), .irq(irq), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_eval();
    int t;
    t = m_n * (m_p + 1);
    if (!m_run) begin
      exp_cnt = m_frozen; exp_tc = 1'b0; exp_busy = 1'b0;
    end else if (!m_mode && m_e > t) begin
      exp_cnt = 0; exp_busy = 1'b0; exp_tc = (m_e == t + 1);
    end else begin
      exp_cnt  = 32'(m_n - ((m_e - 1) % t) / (m_p + 1));
      exp_busy = 1'b1;
      exp_tc   = m_mode && (m_e > 1) && ((m_e - 1) % t == 0);
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    total_cnt++; if (cnt !== '0) $display("FAIL reset_cnt: got %0d expected 0", cnt); else pass_cnt++;
    total_cnt++; if (tc !== 1'b0) $display("FAIL reset_tc: got %0b expected 0", tc); else pass_cnt++;
    total_cnt++; if (irq !== 1'b0) $display("FAIL reset_irq: got %0b expected 0", irq); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy); else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_oneshot();
    logic [31:0] e_cnt;
    mode = 1'b0; load_val = 5; psc_val = 0; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      start = 1'b0;
      e_cnt = (c <= 5) ? 32'(6 - c) : 32'd0;
      total_cnt++; if (cnt !== e_cnt) $display("FAIL oneshot_cnt c%0d: got %0d expected %0d", c, cnt, e_cnt); else pass_cnt++;
      total_cnt++; if (tc !== (c == 6)) $display("FAIL oneshot_tc c%0d: got %0b expected %0b", c, tc, c == 6); else pass_cnt++;
      total_cnt++; if (busy !== (c <= 5)) $display("FAIL oneshot_busy c%0d: got %0b expected %0b", c, busy, c <= 5); else pass_cnt++;
      if (c >= 6) begin
        total_cnt++; if (irq !== 1'b1) $display("FAIL oneshot_irq c%0d: got %0b expected 1", c, irq); else pass_cnt++;
      end
    end
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    total_cnt++; if (irq !== 1'b0) $display("FAIL oneshot_irq_clr: got %0b expected 0", irq); else pass_cnt++;
    $display("test_oneshot done");
  endtask

  task automatic test_periodic();
    logic [31:0] e_cnt;
    mode = 1'b1; load_val = 3; psc_val = 2; start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      start = 1'b0;
      e_cnt = 32'(3 - ((c - 1) % 9) / 3);
      total_cnt++; if (cnt !== e_cnt) $display("FAIL periodic_cnt c%0d: got %0d expected %0d", c, cnt, e_cnt); else pass_cnt++;
      total_cnt++; if (tc !== (c == 10 || c == 19 || c == 28)) $display("FAIL periodic_tc c%0d: got %0b", c, tc); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1) $display("FAIL periodic_busy c%0d: got %0b expected 1", c, busy); else pass_cnt++;
      if (c == 5) load_val = 7;
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL periodic_stop_busy: got %0b expected 0", busy); else pass_cnt++;
    $display("test_periodic done");
  endtask

  task automatic test_stop();
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    mode = 1'b0; load_val = 8; psc_val = 0; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin tick(); start = 1'b0; end
    total_cnt++; if (cnt !== 32'd4) $display("FAIL stop_pre_cnt: got %0d expected 4", cnt); else pass_cnt++;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL stop_busy: got %0b expected 0", busy); else pass_cnt++;
    total_cnt++; if (cnt !== 32'd4) $display("FAIL stop_cnt: got %0d expected 4", cnt); else pass_cnt++;
    total_cnt++; if (tc !== 1'b0) $display("FAIL stop_tc: got %0b expected 0", tc); else pass_cnt++;
    tick(); tick();
    total_cnt++; if (cnt !== 32'd4) $display("FAIL stop_hold_cnt: got %0d expected 4", cnt); else pass_cnt++;
    total_cnt++; if (irq !== 1'b0) $display("FAIL stop_irq: got %0b expected 0", irq); else pass_cnt++;
    load_val = 8; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin tick(); start = 1'b0; end
    stop = 1'b1; start = 1'b1; load_val = 9;
    tick();
    stop = 1'b0; start = 1'b0;
    total_cnt++; if (cnt !== 32'd4) $display("FAIL stopstart_cnt: got %0d expected 4", cnt); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL stopstart_busy: got %0b expected 0", busy); else pass_cnt++;
    total_cnt++; if (tc !== 1'b0) $display("FAIL stopstart_tc: got %0b expected 0", tc); else pass_cnt++;
    tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL stopstart_idle: got %0b expected 0", busy); else pass_cnt++;
    $display("test_stop done");
  endtask

  task automatic test_zero_restart();
    load_val = 0; start = 1'b1;
    tick();
    start = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL zero_busy: got %0b expected 0", busy); else pass_cnt++;
    total_cnt++; if (cnt !== 32'd4) $display("FAIL zero_cnt: got %0d expected 4", cnt); else pass_cnt++;
    mode = 1'b0; psc_val = 0; load_val = 10; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start = 1'b0;
      if (c == 3) begin
        total_cnt++; if (cnt !== 32'd8) $display("FAIL zero_midrun_cnt: got %0d expected 8", cnt); else pass_cnt++;
      end
      if (c == 2) begin start = 1'b1; load_val = 0; end
    end
    total_cnt++; if (cnt !== 32'd6) $display("FAIL restart_pre_cnt: got %0d expected 6", cnt); else pass_cnt++;
    load_val = 2; start = 1'b1;
    tick();
    start = 1'b0;
    total_cnt++; if (cnt !== 32'd2) $display("FAIL restart_cnt: got %0d expected 2", cnt); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL restart_busy: got %0b expected 1", busy); else pass_cnt++;
    tick();
    total_cnt++; if (tc !== 1'b0) $display("FAIL restart_early_tc: got %0b expected 0", tc); else pass_cnt++;
    tick();
    total_cnt++; if (tc !== 1'b1) $display("FAIL restart_tc: got %0b expected 1", tc); else pass_cnt++;
    total_cnt++; if (cnt !== 32'd0) $display("FAIL restart_done_cnt: got %0d expected 0", cnt); else pass_cnt++;
    $display("test_zero_restart done");
  endtask

  task automatic test_irq_collision();
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    total_cnt++; if (irq !== 1'b0) $display("FAIL coll_pre_irq: got %0b expected 0", irq); else pass_cnt++;
    mode = 1'b0; psc_val = 0; load_val = 2; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    total_cnt++; if (tc !== 1'b1) $display("FAIL coll_tc: got %0b expected 1", tc); else pass_cnt++;
    total_cnt++; if (irq !== 1'b1) $display("FAIL coll_irq: got %0b expected 1", irq); else pass_cnt++;
    tick();
    total_cnt++; if (irq !== 1'b1) $display("FAIL coll_irq_hold: got %0b expected 1", irq); else pass_cnt++;
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    total_cnt++; if (irq !== 1'b0) $display("FAIL coll_irq_clr: got %0b expected 0", irq); else pass_cnt++;
    $display("test_irq_collision done");
  endtask

  task automatic test_random();
    rst = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; stop = 1'b0; irq_clr = 1'b0;
    m_run = 1'b0; m_frozen = 0; m_irq = 1'b0; m_e = 0; m_n = 1; m_p = 0; m_mode = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      model_eval();
      total_cnt++; if (cnt !== exp_cnt) $display("FAIL rand_cnt i%0d: got %0d expected %0d", i, cnt, exp_cnt); else pass_cnt++;
      total_cnt++; if (tc !== exp_tc) $display("FAIL rand_tc i%0d: got %0b expected %0b", i, tc, exp_tc); else pass_cnt++;
      total_cnt++; if (busy !== exp_busy) $display("FAIL rand_busy i%0d: got %0b expected %0b", i, busy, exp_busy); else pass_cnt++;
      total_cnt++; if (irq !== m_irq) $display("FAIL rand_irq i%0d: got %0b expected %0b", i, irq, m_irq); else pass_cnt++;
      rst      = ($urandom_range(199) == 0);
      stop     = ($urandom_range(39) == 0);
      start    = ($urandom_range(14) == 0);
      irq_clr  = ($urandom_range(9) == 0);
      mode     = 1'($urandom_range(1));
      load_val = 32'($urandom_range(6));
      psc_val  = 8'($urandom_range(3));
      if (rst) begin
        m_run = 1'b0; m_frozen = 0; m_irq = 1'b0;
      end else begin
        if (stop) begin
          if (m_run) m_frozen = exp_cnt;
          m_run = 1'b0;
        end else if (start && load_val != 0) begin
          m_run = 1'b1; m_e = 1; m_n = int'(load_val); m_p = int'(psc_val); m_mode = mode;
        end else if (m_run) begin
          m_e++;
        end
        model_eval();
        m_irq = exp_tc | (m_irq & !irq_clr);
      end
      tick();
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; irq_clr = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    tick();
    test_reset();
    test_oneshot();
    test_periodic();
    test_stop();
    test_zero_restart();
    test_irq_collision();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
